// File: rtl/comando_irrigacao.sv
// comando_irrigacao: command-side sequencer driving the irrigation tank FSM requests,
// with per-phase timers, fill-timeout fault and completed-cycle counter.
module comando_irrigacao #(
    parameter int CW        = 8,
    parameter int T_IRRIG   = 16,
    parameter int T_LIMPEZA = 8,
    parameter int T_ENCHER  = 64
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          S_Enchendo,
    input  logic          S_Cheio,
    input  logic          S_Erro,
    input  logic          H,
    input  logic          L,
    input  logic          Seco,
    input  logic          Modo,
    output logic          Ve,
    output logic          Bs,
    output logic          Vs,
    output logic          Li,
    output logic          Falha,
    output logic [CW-1:0] Ciclos
);
    typedef enum logic [2:0] {
        ENCHER  = 3'd0,
        AGUARDA = 3'd1,
        IRRIGA  = 3'd2,
        LIMPA   = 3'd3,
        ERRO    = 3'd4,
        FALHA   = 3'd5
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] timer;
    logic          modo_lat, modo_nxt, conta;
    logic          ve_d, bs_d, vs_d, li_d, falha_d;
    logic          unused_enchendo;

    assign unused_enchendo = S_Enchendo;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ENCHER;
            timer    <= '0;
            Ciclos   <= '0;
            modo_lat <= 1'b0;
            {Ve, Bs, Vs, Li, Falha} <= '0;
        end else begin
            state    <= state_nxt;
            timer    <= (state_nxt != state) ? '0 : timer + {{(CW-1){1'b0}}, timer != '1};
            Ciclos   <= Ciclos + {{(CW-1){1'b0}}, conta};
            modo_lat <= modo_nxt;
            {Ve, Bs, Vs, Li, Falha} <= {ve_d, bs_d, vs_d, li_d, falha_d};
        end
    end

    always_comb begin
        state_nxt = state;
        modo_nxt  = modo_lat;
        conta     = 1'b0;
        case (state)
            ENCHER:  state_nxt = H ? AGUARDA : (timer == CW'(T_ENCHER - 1)) ? FALHA : ENCHER;
            AGUARDA: if (S_Cheio && Seco) begin
                state_nxt = IRRIGA;
                modo_nxt  = Modo;
            end
            IRRIGA:  if (L || timer == CW'(T_IRRIG - 1)) begin
                state_nxt = LIMPA;
                conta     = 1'b1;
            end
            LIMPA:   state_nxt = (timer == CW'(T_LIMPEZA - 1)) ? ENCHER : LIMPA;
            ERRO:    state_nxt = S_Erro ? ERRO : ENCHER;
            FALHA:   state_nxt = FALHA;
            default: state_nxt = ENCHER;
        endcase
        // error override pre-empts any phase exit, so an aborted irrigation is not counted
        if (S_Erro && state inside {ENCHER, AGUARDA, IRRIGA, LIMPA, ERRO}) begin
            state_nxt = ERRO;
            modo_nxt  = modo_lat;
            conta     = 1'b0;
        end
    end

    always_comb begin
        ve_d    = state_nxt == ENCHER;
        bs_d    = state_nxt == IRRIGA && !modo_nxt;
        vs_d    = state_nxt == IRRIGA && modo_nxt;
        li_d    = state_nxt == LIMPA;
        falha_d = state_nxt == FALHA;
    end
endmodule

// File: tb/tb_comando_irrigacao.sv
// tb_comando_irrigacao: randomized stimulus against a phase/duration reference model.
module tb_comando_irrigacao;
    localparam int CW = 8, T_IRRIG = 16, T_LIMPEZA = 8, T_ENCHER = 64;
    localparam int P_FILL = 0, P_WAIT = 1, P_IRR = 2, P_CLEAN = 3, P_ERR = 4, P_FAULT = 5;

    logic          Clock = 0, Reset, S_Enchendo, S_Cheio, S_Erro, H, L, Seco, Modo;
    logic          Ve, Bs, Vs, Li, Falha;
    logic [CW-1:0] Ciclos;

    int  errors = 0, checks = 0;
    int  phase = P_FILL, age = 0, cyc = 0;
    bit  mlat = 0, quiet = 1;

    comando_irrigacao #(.CW(CW), .T_IRRIG(T_IRRIG), .T_LIMPEZA(T_LIMPEZA), .T_ENCHER(T_ENCHER)) dut (
        .Clock(Clock), .Reset(Reset), .S_Enchendo(S_Enchendo), .S_Cheio(S_Cheio),
        .S_Erro(S_Erro), .H(H), .L(L), .Seco(Seco), .Modo(Modo),
        .Ve(Ve), .Bs(Bs), .Vs(Vs), .Li(Li), .Falha(Falha), .Ciclos(Ciclos)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_step();
        int np;
        if (Reset) begin
            phase = P_FILL; age = 0; cyc = 0; mlat = 0; quiet = 1;
            return;
        end
        quiet = 0;
        np = phase;
        if (S_Erro && phase != P_FAULT) np = P_ERR;
        else if (phase == P_FILL) np = H ? P_WAIT : (age == T_ENCHER - 1 ? P_FAULT : P_FILL);
        else if (phase == P_WAIT && S_Cheio && Seco) begin
            np = P_IRR;
            mlat = Modo;
        end else if (phase == P_IRR && (L || age == T_IRRIG - 1)) begin
            np = P_CLEAN;
            cyc = (cyc + 1) % (1 << CW);
        end else if (phase == P_CLEAN && age == T_LIMPEZA - 1) np = P_FILL;
        else if (phase == P_ERR && !S_Erro) np = P_FILL;
        age = (np != phase) ? 0 : (age < (1 << CW) - 1 ? age + 1 : age);
        phase = np;
    endfunction

    task automatic compare();
        check("Ve", Ve, int'(!quiet && phase == P_FILL));
        check("Bs", Bs, int'(!quiet && phase == P_IRR && !mlat));
        check("Vs", Vs, int'(!quiet && phase == P_IRR && mlat));
        check("Li", Li, int'(!quiet && phase == P_CLEAN));
        check("Falha", Falha, int'(!quiet && phase == P_FAULT));
        check("Ciclos", int'(Ciclos), cyc);
        check("exclusive", int'($countones({Ve, Bs, Vs, Li}) <= 1), 1);
    endtask

    task automatic run(input int n, input int ph, input int pc, input int ps,
                       input int pl, input int pe, input int pr);
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            Reset      = $urandom_range(99) < pr;
            H          = $urandom_range(99) < ph;
            S_Cheio    = $urandom_range(99) < pc;
            Seco       = $urandom_range(99) < ps;
            L          = $urandom_range(99) < pl;
            S_Erro     = $urandom_range(99) < pe;
            Modo       = 1'($urandom_range(1));
            S_Enchendo = 1'($urandom_range(1));
            @(posedge Clock);
            model_step();
            #1 compare();
        end
    endtask

    task automatic reset_cycle();
        run(1, 50, 50, 50, 50, 50, 100);
        check("rst_Ciclos", int'(Ciclos), 0);
        check("rst_outs", int'({Ve, Bs, Vs, Li, Falha}), 0);
    endtask

    initial begin
        {Reset, S_Enchendo, S_Cheio, S_Erro, H, L, Seco, Modo} = '0;
        reset_cycle();
        run(5, 0, 0, 0, 0, 0, 0);
        check("fill_ve", Ve, 1);
        run(60, 100, 100, 100, 0, 0, 0);
        run(2000, 40, 60, 60, 5, 3, 1);
        reset_cycle();
        run(T_ENCHER + 10, 0, 50, 50, 50, 0, 0);
        check("fault_set", Falha, 1);
        check("fault_ve", Ve, 0);
        run(40, 50, 50, 50, 50, 50, 0);
        check("fault_sticky", Falha, 1);
        reset_cycle();
        check("fault_cleared", Falha, 0);
        run(8000, 100, 100, 100, 2, 0, 0);
        run(2000, 30, 50, 50, 10, 10, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
